// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, field extraction helpers and the
// receive-endpoint handshake state encoding.
package noc_pkg;

    localparam int SIZE        = 8;
    localparam int SRC_ID_BITS = 4;
    localparam int SEQ_BITS    = 4;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        ACK  = 2'd2
    } rx_state_e;

    function automatic logic [SRC_ID_BITS-1:0] src_of(input logic [SIZE-1:0] flit);
        return flit[SIZE-1 -: SRC_ID_BITS];
    endfunction

    function automatic logic [SEQ_BITS-1:0] seq_of(input logic [SIZE-1:0] flit);
        return flit[SEQ_BITS-1:0];
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with occupancy counter; when empty the read port keeps
// showing the most recently popped word (0 after reset).
module noc_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = {(DEPTH_LOG2+1){1'b0}};

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [WIDTH-1:0]      r_last;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = r_level[DEPTH_LOG2];
    assign o_empty = (r_level == LVL_ZERO);
    assign o_level = r_level;
    assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage, pointers, occupancy and last-popped word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
            r_level  <= LVL_ZERO;
            r_last   <= {WIDTH{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/noc_rx_endpoint.sv
// Receiving NoC endpoint: 4-phase req/ack capture into a FIFO with traffic stats.
// Per-source sequence checking is built only when NOC_RX_SEQ_CHECK_EN is defined.
import noc_pkg::*;

module noc_rx_endpoint #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_req,
    input  logic [SIZE-1:0]        rx_data,
    output logic                   rx_ack,
    output logic                   out_valid,
    output logic [SIZE-1:0]        out_data,
    input  logic                   out_ready,
    output logic [CNT_BITS-1:0]    rx_count,
    output logic [CNT_BITS-1:0]    err_count,
    output logic [SRC_ID_BITS-1:0] last_err_src,
    output logic [DEPTH_LOG2:0]    fifo_level
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    rx_state_e           r_state;
    rx_state_e           w_next;
    logic                r_ack;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [CNT_BITS-1:0] r_rx_count;

    // Handshake next-state; capture only from IDLE against the registered full flag
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        case (r_state)
            SYNC: begin
                if (!rx_req) begin
                    w_next = IDLE;
                end else begin
                    w_next = SYNC;
                end
            end
            IDLE: begin
                if (rx_req && !w_full) begin
                    w_push = 1'b1;
                    w_next = ACK;
                end else begin
                    w_next = IDLE;
                end
            end
            ACK: begin
                if (!rx_req) begin
                    w_next = IDLE;
                end else begin
                    w_next = ACK;
                end
            end
            default: w_next = SYNC;
        endcase
    end

    // State, registered acknowledge and accepted-flit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= SYNC;
            r_ack      <= 1'b0;
            r_rx_count <= {CNT_BITS{1'b0}};
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == ACK);
            if (w_push) begin
                r_rx_count <= r_rx_count + CNT_ONE;
            end
        end
    end

    noc_sync_fifo #(
        .WIDTH      (SIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (rx_data),
        .i_pop   (out_ready),
        .o_rdata (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign rx_ack    = r_ack;
    assign out_valid = !w_empty;
    assign rx_count  = r_rx_count;

`ifdef NOC_RX_SEQ_CHECK_EN
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [SEQ_BITS-1:0] SEQ_ONE = {{(SEQ_BITS-1){1'b0}}, 1'b1};

    logic [SEQ_BITS-1:0]    r_exp [1 << SRC_ID_BITS];
    logic [CNT_BITS-1:0]    r_err_count;
    logic [SRC_ID_BITS-1:0] r_last_err_src;
    logic [SRC_ID_BITS-1:0] w_src;
    logic [SEQ_BITS-1:0]    w_seq;

    assign w_src = src_of(rx_data);
    assign w_seq = seq_of(rx_data);

    // Expected sequence always follows the received one, so a gap costs one error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < (1 << SRC_ID_BITS); i++) begin
                r_exp[i] <= {SEQ_BITS{1'b0}};
            end
            r_err_count    <= {CNT_BITS{1'b0}};
            r_last_err_src <= {SRC_ID_BITS{1'b0}};
        end else if (w_push) begin
            r_exp[w_src] <= w_seq + SEQ_ONE;
            if (w_seq != r_exp[w_src]) begin
                r_last_err_src <= w_src;
                if (r_err_count != CNT_MAX) begin
                    r_err_count <= r_err_count + CNT_ONE;
                end
            end
        end
    end

    assign err_count    = r_err_count;
    assign last_err_src = r_last_err_src;
`else
    assign err_count    = {CNT_BITS{1'b0}};
    assign last_err_src = {SRC_ID_BITS{1'b0}};
`endif

endmodule
